mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-low reset, asserted when 0.
REQ-003 The block SHALL have the data-side inputs d_read_in (1), d_write_in (1), d_addr_in (32), d_wdata_in (32) and d_mask_in (8), fed from the execute stage memory outputs.
REQ-004 The block SHALL have the data-side outputs d_stall_out (1), d_rvalid_out (1) and d_rdata_out (32).
REQ-005 The block SHALL have the instruction-side inputs i_read_in (1) and i_addr_in (32), and the outputs i_stall_out (1), i_rvalid_out (1) and i_rdata_out (32).
REQ-006 The block SHALL have the memory-side outputs mem_req_out (1), mem_we_out (1), mem_addr_out (32), mem_wdata_out (32) and mem_mask_out (8), and the inputs mem_ready_in (1), mem_rvalid_in (1) and mem_rdata_in (32).

Function
REQ-007 Each requester SHALL own a one-entry pending slot holding operation, address, data and mask.
REQ-008 A request SHALL be accepted into its slot at a rising edge where the request input is 1 and the matching stall output is 0.
REQ-009 d_stall_out and i_stall_out SHALL equal their slot-valid bits; a request made while stalled is not captured.
REQ-010 If d_write_in and d_read_in are both 1, the write SHALL be captured and the read dropped.
REQ-011 The FSM SHALL have three states: IDLE, ISSUE and WAIT_RD.
REQ-012 In IDLE with at least one slot valid, the FSM SHALL register the grant and enter ISSUE on the next edge.
REQ-013 In ISSUE, mem_req_out SHALL be 1 and the mem_* fields SHALL be driven from the granted slot, held stable until mem_ready_in=1.
REQ-014 When a write handshakes in ISSUE (mem_req_out=1 and mem_ready_in=1), the slot SHALL be freed and the FSM SHALL return to IDLE.
REQ-015 When a read handshakes in ISSUE, the FSM SHALL move to WAIT_RD.
REQ-016 In WAIT_RD, on mem_rvalid_in=1 the owner's rvalid output SHALL pulse 1 for exactly one cycle on the next cycle, with rdata registered from mem_rdata_in; the slot SHALL be freed and the FSM SHALL return to IDLE.
REQ-017 Latency SHALL be as follows: request at edge N gives stall=1 in N+1 and mem_req_out=1 in N+2; a write with ready in N+2 gives stall=0 in N+3.
REQ-018 mem_rvalid_in outside WAIT_RD SHALL be ignored.
REQ-019 mem_req_out, mem_we_out and both rvalid outputs SHALL be 0 outside their qualifying states.
REQ-020 The mem_* data fields SHALL be 0 when mem_req_out=0.
REQ-021 Slot freeing and a new request in the same cycle SHALL NOT overlap; the new request is accepted from the following edge onward.
REQ-022 At most one memory transaction SHALL be outstanding at any time.

Reset
REQ-023 While reset=0 at a rising edge, both slots SHALL clear, the FSM SHALL go to IDLE and the grant pointer SHALL go to data.
REQ-024 While reset=0 at a rising edge, all outputs SHALL be 0.
REQ-025 A reset asserted mid-ISSUE or mid-WAIT_RD SHALL abandon the transaction; a later mem_rvalid_in for it SHALL be ignored.

Configuration
REQ-026 With MEM_ARB_RR_EN defined, an IDLE tie (both slots valid) SHALL be granted to the requester not granted last; the last-grant bit updates on each grant.
REQ-027 With MEM_ARB_RR_EN undefined, ties SHALL always be granted to the data side (fixed priority) and no last-grant state exists.

Verification
REQ-028 The bench SHALL cover a data write: d_write_in=1, addr 0x100, data 0xDEADBEEF, mask 0x0F at edge N, mem_ready_in=1 -> mem_req_out=1, mem_we_out=1 with those fields in N+2, and d_stall_out=0 in N+3.
REQ-029 The bench SHALL cover an instruction read: i_read_in=1, addr 0x40, ready on first ISSUE cycle, mem_rvalid_in 3 cycles later with 0x00000013 -> i_rvalid_out one-cycle pulse with i_rdata_out=0x00000013.
REQ-030 The bench SHALL cover a tie: both requests at the same edge -> data served first; with MEM_ARB_RR_EN on a second tie, instruction is served first.
REQ-031 The bench SHALL cover backpressure: mem_ready_in=0 for 5 cycles -> mem_req_out and fields stable for 5 cycles, stall held, requests during stall not captured.
REQ-032 The bench SHALL cover reset during WAIT_RD: reset=0 for 1 cycle, then mem_rvalid_in=1 -> no rvalid output, both stalls 0, FSM IDLE.
REQ-033 The bench SHALL cover a simultaneous read and write: d_read_in=1 and d_write_in=1 together -> a single write transaction and no read data returned.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester and memory signals for mem_port_arbiter.
// The arbiter takes the slave side; requesters and the memory model take the master side.
interface mem_port_arbiter_if;
  // A request is taken on a rising edge where it is 1 and its stall is 0. A memory
  // transfer completes on a rising edge where mem_req_out=1 and mem_ready_in=1.
  // Read data returns later, qualified by a one-cycle mem_rvalid_in.
  logic        d_read_in;
  logic        d_write_in;
  logic [31:0] d_addr_in;
  logic [31:0] d_wdata_in;
  logic [7:0]  d_mask_in;
  logic        d_stall_out;
  logic        d_rvalid_out;
  logic [31:0] d_rdata_out;

  logic        i_read_in;
  logic [31:0] i_addr_in;
  logic        i_stall_out;
  logic        i_rvalid_out;
  logic [31:0] i_rdata_out;

  logic        mem_req_out;
  logic        mem_we_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_wdata_out;
  logic [7:0]  mem_mask_out;
  logic        mem_ready_in;
  logic        mem_rvalid_in;
  logic [31:0] mem_rdata_in;

  modport slave (
    input  d_read_in, d_write_in, d_addr_in, d_wdata_in, d_mask_in,
    output d_stall_out, d_rvalid_out, d_rdata_out,
    input  i_read_in, i_addr_in,
    output i_stall_out, i_rvalid_out, i_rdata_out,
    output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_mask_out,
    input  mem_ready_in, mem_rvalid_in, mem_rdata_in
  );

  modport master (
    output d_read_in, d_write_in, d_addr_in, d_wdata_in, d_mask_in,
    input  d_stall_out, d_rvalid_out, d_rdata_out,
    output i_read_in, i_addr_in,
    input  i_stall_out, i_rvalid_out, i_rdata_out,
    input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, mem_mask_out,
    output mem_ready_in, mem_rvalid_in, mem_rdata_in
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (data/instruction) arbiter onto a single memory port, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise data always wins ties.
module mem_port_arbiter (
  input  logic                    clk,
  input  logic                    reset,
  mem_port_arbiter_if.slave       bus,
  output logic [1:0]              dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_i_q, gnt_i_d;

  logic        d_vld_q, d_vld_d;
  logic        d_we_q, d_we_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [7:0]  d_mask_q, d_mask_d;

  logic        i_vld_q, i_vld_d;
  logic [31:0] i_addr_q, i_addr_d;

  logic        d_rvalid_q, d_rvalid_d;
  logic        i_rvalid_q, i_rvalid_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;

  logic        d_accept, i_accept, pick_i, cur_we, issue;
  logic        free_d, free_i;

`ifdef MEM_ARB_RR_EN
  logic        prio_i_q, prio_i_d;
  assign pick_i = i_vld_q & (~d_vld_q | prio_i_q);
`else
  assign pick_i = i_vld_q & ~d_vld_q;
`endif

  // Accept only into an empty slot; a slot freed this cycle still reads as full.
  assign d_accept = (bus.d_read_in | bus.d_write_in) & ~d_vld_q;
  assign i_accept = bus.i_read_in & ~i_vld_q;
  assign cur_we   = ~gnt_i_q & d_we_q;

  always_comb begin
    state_d    = state_q;
    gnt_i_d    = gnt_i_q;
    free_d     = 1'b0;
    free_i     = 1'b0;
    d_rvalid_d = 1'b0;
    i_rvalid_d = 1'b0;
    d_rdata_d  = d_rdata_q;
    i_rdata_d  = i_rdata_q;
`ifdef MEM_ARB_RR_EN
    prio_i_d   = prio_i_q;
`endif

    case (state_q)
      IDLE: begin
        if (d_vld_q | i_vld_q) begin
          gnt_i_d = pick_i;
          state_d = ISSUE;
`ifdef MEM_ARB_RR_EN
          prio_i_d = ~pick_i;
`endif
        end
      end
      ISSUE: begin
        if (bus.mem_ready_in) begin
          if (cur_we) begin
            free_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (bus.mem_rvalid_in) begin
          if (gnt_i_q) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = bus.mem_rdata_in;
            free_i     = 1'b1;
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = bus.mem_rdata_in;
            free_d     = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    d_vld_d   = d_vld_q;
    d_we_d    = d_we_q;
    d_addr_d  = d_addr_q;
    d_wdata_d = d_wdata_q;
    d_mask_d  = d_mask_q;
    if (free_d) begin
      d_vld_d = 1'b0;
    end else if (d_accept) begin
      d_vld_d   = 1'b1;
      d_we_d    = bus.d_write_in;
      d_addr_d  = bus.d_addr_in;
      d_wdata_d = bus.d_wdata_in;
      d_mask_d  = bus.d_mask_in;
    end

    i_vld_d  = i_vld_q;
    i_addr_d = i_addr_q;
    if (free_i) begin
      i_vld_d = 1'b0;
    end else if (i_accept) begin
      i_vld_d  = 1'b1;
      i_addr_d = bus.i_addr_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_i_q    <= 1'b0;
      d_vld_q    <= 1'b0;
      d_we_q     <= 1'b0;
      d_addr_q   <= '0;
      d_wdata_q  <= '0;
      d_mask_q   <= '0;
      i_vld_q    <= 1'b0;
      i_addr_q   <= '0;
      d_rvalid_q <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
      i_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
      prio_i_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_i_q    <= gnt_i_d;
      d_vld_q    <= d_vld_d;
      d_we_q     <= d_we_d;
      d_addr_q   <= d_addr_d;
      d_wdata_q  <= d_wdata_d;
      d_mask_q   <= d_mask_d;
      i_vld_q    <= i_vld_d;
      i_addr_q   <= i_addr_d;
      d_rvalid_q <= d_rvalid_d;
      i_rvalid_q <= i_rvalid_d;
      d_rdata_q  <= d_rdata_d;
      i_rdata_q  <= i_rdata_d;
`ifdef MEM_ARB_RR_EN
      prio_i_q   <= prio_i_d;
`endif
    end
  end

  // Outputs are forced low while reset is held so nothing leaks during the reset cycle.
  assign issue             = (state_q == ISSUE) & reset;
  assign bus.mem_req_out   = issue;
  assign bus.mem_we_out    = issue & cur_we;
  assign bus.mem_addr_out  = issue ? (gnt_i_q ? i_addr_q : d_addr_q) : '0;
  assign bus.mem_wdata_out = (issue & ~gnt_i_q) ? d_wdata_q : '0;
  assign bus.mem_mask_out  = (issue & ~gnt_i_q) ? d_mask_q : '0;

  assign bus.d_stall_out   = d_vld_q & reset;
  assign bus.i_stall_out   = i_vld_q & reset;
  assign bus.d_rvalid_out  = d_rvalid_q & reset;
  assign bus.i_rvalid_out  = i_rvalid_q & reset;
  assign bus.d_rdata_out   = reset ? d_rdata_q : '0;
  assign bus.i_rdata_out   = reset ? i_rdata_q : '0;

  assign dbg_state_o       = reset ? state_q : IDLE;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table plus hand-written
// backpressure and reset-during-read sequences. Honours MEM_ARB_RR_EN for tie expectations.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  logic [1:0] dbg_state;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic        drd;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwd;
    logic [7:0]  dmask;
    logic        ird;
    logic [31:0] iaddr;
    logic        rdy;
    logic        rv;
    logic [31:0] rdat;
    logic        edst;
    logic        eist;
    logic        ereq;
    logic        ewe;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [7:0]  emask;
    logic        edrv;
    logic        eirv;
    logic [31:0] erd;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   bad;

  task automatic add(input int rst, drd, dwr, daddr, dwd, dmask, ird, iaddr, rdy, rv, rdat,
                     input int edst, eist, ereq, ewe, eaddr, ewd, emask, edrv, eirv, erd);
    vec_t v;
    v.rst = rst[0];   v.drd = drd[0];   v.dwr = dwr[0];
    v.daddr = daddr;  v.dwd = dwd;      v.dmask = dmask[7:0];
    v.ird = ird[0];   v.iaddr = iaddr;
    v.rdy = rdy[0];   v.rv = rv[0];     v.rdat = rdat;
    v.edst = edst[0]; v.eist = eist[0]; v.ereq = ereq[0]; v.ewe = ewe[0];
    v.eaddr = eaddr;  v.ewd = ewd;      v.emask = emask[7:0];
    v.edrv = edrv[0]; v.eirv = eirv[0]; v.erd = erd;
    vq.push_back(v);
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    reset             = v.rst;
    bus.d_read_in     = v.drd;
    bus.d_write_in    = v.dwr;
    bus.d_addr_in     = v.daddr;
    bus.d_wdata_in    = v.dwd;
    bus.d_mask_in     = v.dmask;
    bus.i_read_in     = v.ird;
    bus.i_addr_in     = v.iaddr;
    bus.mem_ready_in  = v.rdy;
    bus.mem_rvalid_in = v.rv;
    bus.mem_rdata_in  = v.rdat;
  endtask

  task automatic drive_idle(input logic rdy);
    reset             = 1'b1;
    bus.d_read_in     = 1'b0;
    bus.d_write_in    = 1'b0;
    bus.d_addr_in     = '0;
    bus.d_wdata_in    = '0;
    bus.d_mask_in     = '0;
    bus.i_read_in     = 1'b0;
    bus.i_addr_in     = '0;
    bus.mem_ready_in  = rdy;
    bus.mem_rvalid_in = 1'b0;
    bus.mem_rdata_in  = '0;
  endtask

  // scoreboard compare
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_row(input int k, input vec_t v);
    chk($sformatf("r%0d d_stall", k), 32'(bus.d_stall_out), 32'(v.edst));
    chk($sformatf("r%0d i_stall", k), 32'(bus.i_stall_out), 32'(v.eist));
    chk($sformatf("r%0d mem_req", k), 32'(bus.mem_req_out), 32'(v.ereq));
    chk($sformatf("r%0d mem_we", k), 32'(bus.mem_we_out), 32'(v.ewe));
    chk($sformatf("r%0d mem_addr", k), bus.mem_addr_out, v.eaddr);
    chk($sformatf("r%0d mem_wdata", k), bus.mem_wdata_out, v.ewd);
    chk($sformatf("r%0d mem_mask", k), 32'(bus.mem_mask_out), 32'(v.emask));
    chk($sformatf("r%0d d_rvalid", k), 32'(bus.d_rvalid_out), 32'(v.edrv));
    chk($sformatf("r%0d i_rvalid", k), 32'(bus.i_rvalid_out), 32'(v.eirv));
    if (v.edrv) chk($sformatf("r%0d d_rdata", k), bus.d_rdata_out, v.erd);
    if (v.eirv) chk($sformatf("r%0d i_rdata", k), bus.i_rdata_out, v.erd);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive_idle(1'b0);
    reset = 1'b0;

    // reset rows
    add(0,0,0,0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0, 0,0,0);
    add(0,0,0,0,0,0, 0,0, 0,0,0,  0,0,0,0,0,0,0, 0,0,0);
    // data write: request, stall, issue with fields, stall drops; stray rvalid in IDLE
    add(1,0,1,'h100,'hDEADBEEF,'h0F, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,1,'hBAD,  1,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,0,1,1,'h100,'hDEADBEEF,'h0F, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
    // instruction read, data returns 3 cycles after the handshake
    add(1,0,0,0,0,0, 1,'h40, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,1,1,0,'h40,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,1,'h13,  0,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,1,'h13);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
    // first tie: data served first in both modes
    add(1,0,1,'h200,'h11111111,'hFF, 1,'h80, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,1,1,1,'h200,'h11111111,'hFF, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,1,1,0,'h80,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,1,'hCAFEF00D,  0,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,1,'hCAFEF00D);
    // data-only write; a read offered in the freeing cycle must be dropped
    add(1,0,1,'h180,'h55AA55AA,'h01, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,0,0,0,0,0,0, 0,0,0);
    add(1,1,0,'h5,0,0, 0,0, 1,0,0,  1,0,1,1,'h180,'h55AA55AA,'h01, 0,0,0);
    // second tie, last grant was data
    add(1,0,1,'h300,'h22222222,'h3C, 1,'hC0, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,1,0,0,0,0,0, 0,0,0);
`ifdef MEM_ARB_RR_EN
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,1,1,0,'hC0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,1,'h77,  1,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,0,0,0,0,0,0, 0,1,'h77);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,0,1,1,'h300,'h22222222,'h3C, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
`else
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,1,1,1,'h300,'h22222222,'h3C, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,1,1,0,'hC0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,1,'h77,  0,1,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,1,'h77);
`endif
    // read+write together: one write, no read data; stray rvalid afterwards
    add(1,1,1,'h400,'h12345678,'hF0, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  1,0,1,1,'h400,'h12345678,'hF0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,1,'h99,  0,0,0,0,0,0,0, 0,0,0);
    add(1,0,0,0,0,0, 0,0, 1,0,0,  0,0,0,0,0,0,0, 0,0,0);

    foreach (vq[k]) begin
      @(negedge clk);
      drive(vq[k]);
      #1;
      check_row(k, vq[k]);
    end

    // backpressure: ready low for 5 ISSUE cycles, new data requests ignored meanwhile
    @(negedge clk);
    drive_idle(1'b0);
    bus.d_write_in = 1'b1;
    bus.d_addr_in  = 32'h500;
    bus.d_wdata_in = 32'hA5A5A5A5;
    bus.d_mask_in  = 8'h0F;
    @(negedge clk);
    drive_idle(1'b0);
    #1;
    chk("bp stall", 32'(bus.d_stall_out), 32'd1);
    chk("bp req idle", 32'(bus.mem_req_out), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive_idle(1'b0);
      bus.d_write_in = 1'b1;
      bus.d_addr_in  = 32'h600;
      bus.d_wdata_in = 32'h0;
      #1;
      chk($sformatf("bp%0d req", c), 32'(bus.mem_req_out), 32'd1);
      chk($sformatf("bp%0d we", c), 32'(bus.mem_we_out), 32'd1);
      chk($sformatf("bp%0d addr", c), bus.mem_addr_out, 32'h500);
      chk($sformatf("bp%0d wdata", c), bus.mem_wdata_out, 32'hA5A5A5A5);
      chk($sformatf("bp%0d mask", c), 32'(bus.mem_mask_out), 32'h0F);
      chk($sformatf("bp%0d stall", c), 32'(bus.d_stall_out), 32'd1);
    end
    @(negedge clk);
    drive_idle(1'b1);
    #1;
    chk("bp final req", 32'(bus.mem_req_out), 32'd1);
    chk("bp final addr", bus.mem_addr_out, 32'h500);
    @(negedge clk);
    #1;
    chk("bp done stall", 32'(bus.d_stall_out), 32'd0);
    chk("bp done req", 32'(bus.mem_req_out), 32'd0);
    @(negedge clk);
    #1;
    chk("bp after stall", 32'(bus.d_stall_out), 32'd0);
    chk("bp after req", 32'(bus.mem_req_out), 32'd0);

    // reset during WAIT_RD, late rvalid must be ignored
    @(negedge clk);
    drive_idle(1'b1);
    bus.i_read_in = 1'b1;
    bus.i_addr_in = 32'h44;
    @(negedge clk);
    drive_idle(1'b1);
    @(negedge clk);
    #1;
    chk("rst issue req", 32'(bus.mem_req_out), 32'd1);
    chk("rst issue addr", bus.mem_addr_out, 32'h44);
    @(negedge clk);
    #1;
    chk("rst wait state", 32'(dbg_state), 32'd2);
    chk("rst wait stall", 32'(bus.i_stall_out), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst low i_stall", 32'(bus.i_stall_out), 32'd0);
    chk("rst low req", 32'(bus.mem_req_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bus.mem_rvalid_in = 1'b1;
    bus.mem_rdata_in  = 32'hEE;
    #1;
    chk("rst post state", 32'(dbg_state), 32'd0);
    chk("rst post i_stall", 32'(bus.i_stall_out), 32'd0);
    @(negedge clk);
    bus.mem_rvalid_in = 1'b0;
    #1;
    chk("rst end i_rvalid", 32'(bus.i_rvalid_out), 32'd0);
    chk("rst end d_rvalid", 32'(bus.d_rvalid_out), 32'd0);
    chk("rst end i_stall", 32'(bus.i_stall_out), 32'd0);
    chk("rst end d_stall", 32'(bus.d_stall_out), 32'd0);
    chk("rst end state", 32'(dbg_state), 32'd0);
    chk("rst end req", 32'(bus.mem_req_out), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
